dual_port_ram_stream_reader: RTL and testbench

- Read-side engine for the dual-port RAM: owns one RAM port in read-only mode and sweeps a programmed address range.
- Streams the words out on a valid/ready interface with last-beat marking.
- Complements the existing write path; typical use is dumping RAM contents preloaded through the other port into a downstream consumer.
- Tolerates arbitrary downstream backpressure without losing or duplicating words.

---
 rtl/dual_port_ram_stream_reader.sv | 123 ++++++++++++
 tb/tb_dual_port_ram_stream_reader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_stream_reader.sv
// Read-side engine for a dual-port RAM. It sweeps a programmed address range
// on one read-only port and streams the words out on a valid/ready interface.
// A 2-entry skid FIFO absorbs the one-cycle RAM read latency, so the stream
// tolerates any backpressure without dropping or repeating a word.
module dual_port_ram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
    localparam logic [ADDR_WIDTH:0]   CntOne  = 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH:0]   issue_cnt_q;
    logic [ADDR_WIDTH:0]   beat_cnt_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            fifo_cnt_q;

    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;

    // Handshake, FIFO head and the read-issue gate; occupancy counts words
    // already buffered plus the one in flight, net of this cycle's pop.
    always_comb begin
        pop       = m_valid && m_ready;
        push      = inflight_q;
        occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        ram_en    = (state_q == StRun) && (issue_cnt_q != '0) && (occupancy < 3'd2);
        m_valid   = (fifo_cnt_q != 2'd0);
        m_data    = fifo_q[rd_ptr_q];
        m_last    = m_valid && (beat_cnt_q == CntOne);
    end

    // Control FSM, read issue counters and the return-path FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_addr    <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            done       <= 1'b0;
            inflight_q <= ram_en;

            if (ram_en) begin
                ram_addr    <= ram_addr + AddrOne;
                issue_cnt_q <= issue_cnt_q - CntOne;
            end

            if (push) begin
                fifo_q[wr_ptr_q] <= ram_dout;
                wr_ptr_q         <= ~wr_ptr_q;
            end

            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                beat_cnt_q <= beat_cnt_q - CntOne;
            end

            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};

            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len != '0) begin
                            ram_addr    <= base_addr;
                            issue_cnt_q <= len;
                            beat_cnt_q  <= len;
                            busy        <= 1'b1;
                            state_q     <= StRun;
                        end else begin
                            // Empty transfer: report completion without going busy.
                            done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (ram_en && (issue_cnt_q == CntOne)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && m_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_ram_stream_reader.sv
// Directed bench for dual_port_ram_stream_reader with a behavioural RAM
// preloaded as mem[i] = 8'hA0 + i.
module tb_dual_port_ram_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       ram_en;
    logic [3:0] ram_addr;
    logic [7:0] ram_dout;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    logic [7:0] mem [16];

    int n_checks;
    int n_pass;

    dual_port_ram_stream_reader #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .ram_en   (ram_en),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid one cycle after ram_en is sampled.
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulse start for one cycle; returns at the negedge following the sampling edge.
    task automatic do_start(input logic [3:0] b, input logic [4:0] l);
        @(negedge clk);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run one transfer, checking every beat, stall stability, the read-issue
    // limit and done/valid separation. mode 0: ready always; 1: toggling.
    task automatic stream(input string name, input logic [3:0] b, input int l,
                          input int mode, input int poke_c,
                          output int first_c, output int done_c);
        logic [7:0] pat;
        logic [7:0] exp_d;
        logic [7:0] hold_d;
        logic [3:0] a;
        bit         hold;
        bit         got_done;
        bit         stall_bad;
        bit         rule_bad;
        bit         overlap_bad;
        bit         busy_bad;
        int         beats;
        int         issued;
        int         popped;
        int         occ;
        pat = 8'b0110_1001;
        hold = 0; got_done = 0; stall_bad = 0; rule_bad = 0; overlap_bad = 0; busy_bad = 0;
        beats = 0; issued = 0; popped = 0; first_c = -1; done_c = -1; hold_d = 8'h00;
        do_start(b, 5'(l));
        for (int c = 0; c < 300 && !got_done; c++) begin
            m_ready = (mode == 0) ? 1'b1 : pat[c % 8];
            if (c == poke_c) begin
                start = 1'b1; base_addr = 4'd9; len = 5'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                got_done = 1; done_c = c;
                if (m_valid) overlap_bad = 1;
                if (busy) busy_bad = 1;
            end else if (!busy) begin
                busy_bad = 1;
            end
            if (hold && !(m_valid && m_data == hold_d)) stall_bad = 1;
            occ = issued - popped - ((m_valid && m_ready) ? 1 : 0);
            if (ram_en && occ >= 2) rule_bad = 1;
            if (ram_en) issued++;
            if (m_valid && m_ready) begin
                popped++;
                a = b + 4'(beats);
                exp_d = 8'hA0 + {4'h0, a};
                if (first_c < 0) first_c = c;
                check($sformatf("%s_data%0d", name, beats), 32'(m_data), 32'(exp_d));
                check($sformatf("%s_last%0d", name, beats), 32'(m_last),
                      32'(beats == l - 1));
                beats++;
            end
            hold   = m_valid && !m_ready;
            hold_d = m_data;
            @(negedge clk);
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check({name, "_done_seen"}, 32'(got_done), 32'd1);
        check({name, "_beats"}, 32'(beats), 32'(l));
        check({name, "_issued"}, 32'(issued), 32'(l));
        check({name, "_stall_stable_err"}, 32'(stall_bad), 32'd0);
        check({name, "_issue_limit_err"}, 32'(rule_bad), 32'd0);
        check({name, "_done_with_valid_err"}, 32'(overlap_bad), 32'd0);
        check({name, "_busy_err"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        int  first_c;
        int  done_c;
        bit  stray;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        ram_dout  = 8'h00;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 4'd0;
        len       = 5'd0;
        m_ready   = 1'b1;

        #12;
        check("reset_ctrl", {27'd0, busy, done, ram_en, m_valid, m_last}, 32'd0);
        check("reset_addr_data", {20'd0, ram_addr, m_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic transfer with exact latency.
        stream("base0", 4'd0, 4, 0, -1, first_c, done_c);
        check("base0_first_beat_cycle", 32'(first_c), 32'd2);
        check("base0_done_cycle", 32'(done_c), 32'd6);
        #1;
        check("base0_done_one_cycle", 32'(done), 32'd0);

        // Address wrap 14,15,0,1.
        stream("wrap", 4'd14, 4, 0, -1, first_c, done_c);

        // Backpressure with a toggling ready.
        stream("bp", 4'd0, 8, 1, -1, first_c, done_c);

        // Empty transfer.
        do_start(4'd3, 5'd0);
        #1;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        #1;
        check("len0_done_clear", {29'd0, done, busy, m_valid}, 32'd0);

        // Full-depth transfer.
        stream("full", 4'd0, 16, 0, -1, first_c, done_c);
        check("full_done_cycle", 32'(done_c), 32'd18);

        // Start while busy is ignored.
        stream("restart", 4'd5, 4, 0, 3, first_c, done_c);

        // Reset after the second beat of a len=8 transfer.
        m_ready = 1'b1;
        do_start(4'd0, 5'd8);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {27'd0, busy, done, ram_en, m_valid, m_last}, 32'd0);
        check("midreset_addr_data", {20'd0, ram_addr, m_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (m_valid || ram_en || busy || done) stray = 1;
        end
        check("after_reset_quiet", 32'(stray), 32'd0);

        // A fresh transfer still works after reset.
        stream("post_reset", 4'd3, 3, 1, -1, first_c, done_c);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
